// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register file's single write port. Each requester
// feeds a one-entry slot; round-robin grant with same-address writes kept in arrival order.
module rf_write_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [AW-1:0]        req0_addr,
  input  logic [DW-1:0]        req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [AW-1:0]        req1_addr,
  input  logic [DW-1:0]        req1_data,
  output logic                 req1_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_oaddr,
  output logic [DW-1:0]        rf_oin,
  output logic [(1<<AW)-1:0]   busy
);

  localparam int unsigned NReg = 1 << AW;

  logic          slot0_full_q, slot0_full_d;
  logic [AW-1:0] slot0_addr_q, slot0_addr_d;
  logic [DW-1:0] slot0_data_q, slot0_data_d;
  logic          slot1_full_q, slot1_full_d;
  logic [AW-1:0] slot1_addr_q, slot1_addr_d;
  logic [DW-1:0] slot1_data_q, slot1_data_d;
  logic          last_q, last_d;
  logic          older_q, older_d;
  logic          grant0, grant1;
  logic          acc0, acc1;

  // Same-address pairs follow age; otherwise alternate away from the last winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot0_full_q && slot1_full_q) begin
      if (slot0_addr_q == slot1_addr_q) begin
        grant0 = ~older_q;
        grant1 = older_q;
      end else begin
        grant0 = last_q;
        grant1 = ~last_q;
      end
    end else begin
      grant0 = slot0_full_q;
      grant1 = slot1_full_q;
    end
  end

  assign req0_ready = rst | ~slot0_full_q | grant0;
  assign req1_ready = rst | ~slot1_full_q | grant1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  always_comb begin
    rf_we    = (grant0 | grant1) & ~rst;
    rf_oaddr = '0;
    rf_oin   = '0;
    if (!rst) begin
      if (grant0) begin
        rf_oaddr = slot0_addr_q;
        rf_oin   = slot0_data_q;
      end else if (grant1) begin
        rf_oaddr = slot1_addr_q;
        rf_oin   = slot1_data_q;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NReg; i++) begin
      busy[i] = ~rst & ((slot0_full_q & (slot0_addr_q == AW'(i))) |
                        (slot1_full_q & (slot1_addr_q == AW'(i))));
    end
  end

  always_comb begin
    slot0_full_d = acc0 | (slot0_full_q & ~grant0);
    slot0_addr_d = acc0 ? req0_addr : slot0_addr_q;
    slot0_data_d = acc0 ? req0_data : slot0_data_q;
    slot1_full_d = acc1 | (slot1_full_q & ~grant1);
    slot1_addr_d = acc1 ? req1_addr : slot1_addr_q;
    slot1_data_d = acc1 ? req1_data : slot1_data_q;
    last_d       = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_q);
    // A slot holding a fresh entry is younger than a slot that keeps its old one.
    older_d      = older_q;
    if (acc0 && acc1) begin
      older_d = 1'b0;
    end else if (acc0 && slot1_full_q && !grant1) begin
      older_d = 1'b1;
    end else if (acc1 && slot0_full_q && !grant0) begin
      older_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_full_q <= 1'b0;
      slot0_addr_q <= '0;
      slot0_data_q <= '0;
      slot1_full_q <= 1'b0;
      slot1_addr_q <= '0;
      slot1_data_q <= '0;
      last_q       <= 1'b1;
      older_q      <= 1'b0;
    end else begin
      slot0_full_q <= slot0_full_d;
      slot0_addr_q <= slot0_addr_d;
      slot0_data_q <= slot0_data_d;
      slot1_full_q <= slot1_full_d;
      slot1_addr_q <= slot1_addr_d;
      slot1_data_q <= slot1_data_d;
      last_q       <= last_d;
      older_q      <= older_d;
    end
  end

endmodule
